// File: rtl/stack_engine_if.sv
// ---------------------------------------------------------------------------
// stack_engine_if
//   Command/response bundle between the control unit and the operand-stack
//   engine.
//
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high. The master holds cmd_op/cmd_data/cmd_addr
//   stable while cmd_valid is high and not yet accepted. rsp_valid is a
//   single-cycle pulse with no back-pressure; rsp_data is meaningful only
//   while rsp_valid is high.
//
//   Signals:
//     cmd_valid  master->slave  command present
//     cmd_ready  slave->master  engine accepts a command this cycle
//     cmd_op     master->slave  operation code (3 bits)
//     cmd_data   master->slave  PUSH operand
//     cmd_addr   master->slave  LOAD/STORE data memory address
//     rsp_valid  slave->master  popped value available (one-cycle pulse)
//     rsp_data   slave->master  popped value
// ---------------------------------------------------------------------------
interface stack_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_AW     = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [MEM_AW-1:0]     cmd_addr;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_addr,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_addr,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/stack_engine.sv
// ---------------------------------------------------------------------------
// stack_engine
//   Operand stack with the top-of-stack cached in a register, the entries
//   beneath it in a synchronous stack RAM, and an attached data memory for
//   LOAD/STORE. Commands arrive over a valid/ready port; POP/STORE refill
//   the TOS register from the RAM in a second cycle, LOAD waits one cycle
//   for the data memory before pushing.
//
//   Ports:
//     clk              clock
//     reset            synchronous, active-high reset
//     bus              stack_engine_if.slave command/response port
//     err_clr_i        clears both sticky error flags (a new error wins)
//     top_o            current top-of-stack register
//     count_o          number of entries, 0..2**STACK_AW
//     empty_o/full_o   count==0 / count==2**STACK_AW
//     err_overflow_o   sticky: PUSH/DUP/LOAD attempted while full
//     err_underflow_o  sticky: POP/DUP/STORE attempted while empty
//     state_o          FSM state (0 IDLE, 1 REFILL, 2 LOAD_WAIT)
// ---------------------------------------------------------------------------
module stack_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int STACK_AW   = 6,
  parameter int MEM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_engine_if.slave         bus,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic [STACK_AW:0]     count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  err_overflow_o,
  output logic                  err_underflow_o,
  output logic [1:0]            state_o
);

  localparam int STACK_DEPTH = 2 ** STACK_AW;
  localparam int MEM_WORDS   = 2 ** MEM_AW;

  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  localparam logic [STACK_AW:0] CNT_ONE  = (STACK_AW+1)'(1);
  localparam logic [STACK_AW:0] CNT_TWO  = (STACK_AW+1)'(2);
  localparam logic [STACK_AW:0] CNT_FULL = (STACK_AW+1)'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    LOAD_WAIT = 2'd2
  } state_t;

  state_t                state_q;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [DATA_WIDTH-1:0] top_q;
  logic [STACK_AW:0]     count_q;
  logic                  err_ovf_q;
  logic                  err_unf_q;

  logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] stack_rd_q;
  logic [DATA_WIDTH-1:0] data_mem  [MEM_WORDS];
  logic [DATA_WIDTH-1:0] mem_rd_q;

  // Decoded command and memory-port controls
  logic                  accept;
  logic                  is_empty;
  logic                  is_full;
  logic                  do_push;
  logic                  do_pop;
  logic                  do_store;
  logic                  do_load;
  logic                  load_fin;
  logic [DATA_WIDTH-1:0] push_data;
  logic [STACK_AW:0]     count_m1;
  logic [STACK_AW:0]     count_m2;
  logic                  stack_we;
  logic                  stack_re;

  // ready_q is only ever high while IDLE; masking with reset keeps the port
  // closed during the first reset cycle too.
  assign bus.cmd_ready = ready_q & ~reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign top_o           = top_q;
  assign count_o         = count_q;
  assign empty_o         = is_empty;
  assign full_o          = is_full;
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;
  assign state_o         = state_q;

  always_comb begin
    accept    = bus.cmd_valid & bus.cmd_ready;
    is_empty  = (count_q == '0);
    is_full   = (count_q == CNT_FULL);
    count_m1  = count_q - CNT_ONE;
    count_m2  = count_q - CNT_TWO;
    push_data = (bus.cmd_op == OP_PUSH) ? bus.cmd_data : top_q;
    do_push   = accept & ~is_full &
                ((bus.cmd_op == OP_PUSH) | ((bus.cmd_op == OP_DUP) & ~is_empty));
    do_pop    = accept & ~is_empty &
                ((bus.cmd_op == OP_POP) | (bus.cmd_op == OP_STORE));
    do_store  = accept & ~is_empty & (bus.cmd_op == OP_STORE);
    do_load   = accept & ~is_full & (bus.cmd_op == OP_LOAD);
    // The LOAD push completes on the LOAD_WAIT edge; reset aborts it.
    load_fin  = (state_q == LOAD_WAIT) & ~reset;
    // Any push spills the old TOS into the slot just below the new top.
    stack_we  = (do_push | load_fin) & ~is_empty;
    // Any pop leaving entries behind fetches the new top from the RAM.
    stack_re  = do_pop & (count_q >= CNT_TWO);
  end

  // Stack RAM: synchronous write and read, no reset on contents.
  always_ff @(posedge clk) begin
    if (stack_we) stack_mem[count_m1[STACK_AW-1:0]] <= top_q;
    if (stack_re) stack_rd_q <= stack_mem[count_m2[STACK_AW-1:0]];
  end

  // Data memory: STORE writes the current TOS, LOAD reads for LOAD_WAIT.
  always_ff @(posedge clk) begin
    if (do_store) data_mem[bus.cmd_addr] <= top_q;
    if (do_load)  mem_rd_q <= data_mem[bus.cmd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      top_q       <= '0;
      count_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      // Clear first so an error flagged below in the same cycle wins.
      if (err_clr_i) begin
        err_ovf_q <= 1'b0;
        err_unf_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.cmd_op)
              OP_PUSH, OP_DUP: begin
                if (bus.cmd_op == OP_DUP && is_empty) begin
                  err_unf_q <= 1'b1;
                end else if (is_full) begin
                  err_ovf_q <= 1'b1;
                end else begin
                  top_q   <= push_data;
                  count_q <= count_q + CNT_ONE;
                end
              end
              OP_POP, OP_STORE: begin
                if (is_empty) begin
                  err_unf_q <= 1'b1;
                end else begin
                  if (bus.cmd_op == OP_POP) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= top_q;
                  end
                  count_q <= count_m1;
                  if (count_q >= CNT_TWO) begin
                    state_q <= REFILL;
                    ready_q <= 1'b0;
                  end else begin
                    top_q <= '0;
                  end
                end
              end
              OP_LOAD: begin
                if (is_full) begin
                  err_ovf_q <= 1'b1;
                end else begin
                  state_q <= LOAD_WAIT;
                  ready_q <= 1'b0;
                end
              end
              OP_CLEAR: begin
                count_q <= '0;
                top_q   <= '0;
              end
              default: ;  // NOP and reserved opcode
            endcase
          end
        end
        REFILL: begin
          top_q   <= stack_rd_q;
          state_q <= IDLE;
        end
        LOAD_WAIT: begin
          top_q   <= mem_rd_q;
          count_q <= count_q + CNT_ONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// ---------------------------------------------------------------------------
// tb_stack_engine
//   Directed bench for stack_engine built with a 4-entry stack
//   (STACK_AW=2) so the full/overflow boundary is reachable. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_stack_engine;

  localparam int DW  = 8;
  localparam int SAW = 2;
  localparam int MAW = 12;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  logic           clk;
  logic           reset;
  logic           err_clr;
  logic [DW-1:0]  top;
  logic [SAW:0]   count;
  logic           empty;
  logic           full;
  logic           err_ovf;
  logic           err_unf;
  logic [1:0]     state;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  stack_engine_if #(.DATA_WIDTH(DW), .MEM_AW(MAW)) bus ();

  stack_engine #(.DATA_WIDTH(DW), .STACK_AW(SAW), .MEM_AW(MAW)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .err_clr_i       (err_clr),
    .top_o           (top),
    .count_o         (count),
    .empty_o         (empty),
    .full_o          (full),
    .err_overflow_o  (err_ovf),
    .err_underflow_o (err_unf),
    .state_o         (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge; returns on the falling edge just after the
  // accepting rising edge with cmd_valid already dropped.
  task automatic send(input logic [2:0] op, input logic [DW-1:0] data,
                      input logic [MAW-1:0] addr);
    int guard;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_addr  = addr;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    err_clr       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    bus.cmd_addr  = '0;

    repeat (3) @(negedge clk);
    check("rst_ready",   {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_rsp_v",   {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_d",   32'(bus.rsp_data), 32'h0);
    check("rst_top",     32'(top), 32'h0);
    check("rst_count",   32'(count), 32'd0);
    check("rst_empty",   {31'd0, empty}, 32'd1);
    check("rst_full",    {31'd0, full}, 32'd0);
    check("rst_ovf",     {31'd0, err_ovf}, 32'd0);
    check("rst_unf",     {31'd0, err_unf}, 32'd0);
    check("rst_state",   32'(state), 32'd0);
    reset = 1'b0;
    check("ready_at_deassert", {31'd0, bus.cmd_ready}, 32'd0);
    idle_cycle();
    check("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

    // Back-to-back pushes
    send(OP_PUSH, 8'h11, '0);
    check("push1_ready", {31'd0, bus.cmd_ready}, 32'd1);
    send(OP_PUSH, 8'h22, '0);
    check("push2_ready", {31'd0, bus.cmd_ready}, 32'd1);
    send(OP_PUSH, 8'h33, '0);
    check("push3_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("push3_count", 32'(count), 32'd3);
    check("push3_top",   32'(top), 32'h33);

    // Pops return LIFO order; first two need a refill cycle
    exp_q = {8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] exp_v;
      exp_v = exp_q.pop_front();
      send(OP_POP, '0, '0);
      check($sformatf("pop%0d_rsp_v", i), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("pop%0d_rsp_d", i), 32'(bus.rsp_data), 32'(exp_v));
      check($sformatf("pop%0d_count", i), 32'(count), 32'(2 - i));
      check($sformatf("pop%0d_ready", i), {31'd0, bus.cmd_ready}, (i < 2) ? 32'd0 : 32'd1);
      if (i == 0) check("pop0_state_refill", 32'(state), 32'd1);
      idle_cycle();
      check($sformatf("pop%0d_rsp_clr", i), {31'd0, bus.rsp_valid}, 32'd0);
    end
    check("pops_empty", {31'd0, empty}, 32'd1);
    check("pops_top",   32'(top), 32'h0);

    // Fill to capacity, then overflow
    send(OP_PUSH, 8'h01, '0);
    send(OP_PUSH, 8'h02, '0);
    send(OP_PUSH, 8'h03, '0);
    send(OP_PUSH, 8'h04, '0);
    check("fill_full",  {31'd0, full}, 32'd1);
    check("fill_count", 32'(count), 32'd4);
    send(OP_PUSH, 8'h55, '0);
    check("ovf_flag",  {31'd0, err_ovf}, 32'd1);
    check("ovf_top",   32'(top), 32'h04);
    check("ovf_count", 32'(count), 32'd4);
    send(OP_LOAD, '0, 12'h123);
    check("ovf_load_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("ovf_load_count", 32'(count), 32'd4);
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;
    check("ovf_cleared", {31'd0, err_ovf}, 32'd0);
    send(OP_CLEAR, '0, '0);
    check("clear_count", 32'(count), 32'd0);
    check("clear_top",   32'(top), 32'h0);
    check("clear_noerr", {30'd0, err_ovf, err_unf}, 32'd0);

    // Underflow on empty POP and DUP
    send(OP_POP, '0, '0);
    check("unf_pop_flag",  {31'd0, err_unf}, 32'd1);
    check("unf_pop_rsp_v", {31'd0, bus.rsp_valid}, 32'd0);
    check("unf_pop_count", 32'(count), 32'd0);
    err_clr = 1'b1;
    send(OP_DUP, '0, '0);
    err_clr = 1'b0;
    check("unf_dup_set_wins", {31'd0, err_unf}, 32'd1);
    check("unf_dup_count",    32'(count), 32'd0);
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;
    check("unf_cleared", {31'd0, err_unf}, 32'd0);

    // STORE / LOAD round trip through the data memory
    send(OP_PUSH, 8'hA5, '0);
    send(OP_STORE, '0, 12'h123);
    check("store_rsp_v", {31'd0, bus.rsp_valid}, 32'd0);
    check("store_count", 32'(count), 32'd0);
    check("store_top",   32'(top), 32'h0);
    send(OP_LOAD, '0, 12'h123);
    check("load_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    check("load_state",     32'(state), 32'd2);
    check("load_count_mid", 32'(count), 32'd0);
    idle_cycle();
    check("load_count", 32'(count), 32'd1);
    check("load_top",   32'(top), 32'hA5);
    send(OP_DUP, '0, '0);
    check("dup_count", 32'(count), 32'd2);
    check("dup_top",   32'(top), 32'hA5);
    send(OP_POP, '0, '0);
    check("dup_pop1_rsp", 32'(bus.rsp_data), 32'hA5);
    idle_cycle();
    check("dup_pop1_top", 32'(top), 32'hA5);
    send(OP_POP, '0, '0);
    check("dup_pop2_rsp", 32'(bus.rsp_data), 32'hA5);
    check("dup_pop2_count", 32'(count), 32'd0);

    // LOAD onto a non-empty stack spills the old top
    send(OP_PUSH, 8'h77, '0);
    send(OP_LOAD, '0, 12'h123);
    idle_cycle();
    check("spill_count", 32'(count), 32'd2);
    check("spill_top",   32'(top), 32'hA5);
    send(OP_POP, '0, '0);
    check("spill_pop_rsp", 32'(bus.rsp_data), 32'hA5);
    idle_cycle();
    check("spill_refill_top", 32'(top), 32'h77);
    send(OP_CLEAR, '0, '0);

    // Reset during LOAD_WAIT aborts the pending push
    send(OP_PUSH, 8'h3C, '0);
    send(OP_LOAD, '0, 12'h123);
    check("abort_state_pre", 32'(state), 32'd2);
    reset = 1'b1;
    idle_cycle();
    check("abort_count", 32'(count), 32'd0);
    check("abort_top",   32'(top), 32'h0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_ready", {31'd0, bus.cmd_ready}, 32'd0);
    reset = 1'b0;
    idle_cycle();
    check("abort_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
    check("abort_count_post", 32'(count), 32'd0);
    send(OP_PUSH, 8'h42, '0);
    check("post_abort_top", 32'(top), 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
